// File: rtl/offset_cal_scheduler.sv
// offset_cal_scheduler: calibrates channels one at a time through a shared offset calculator, then applies saturating correction; define CAL_TIMEOUT_EN to add the watchdog
module offset_cal_scheduler #(
   parameter int NUM_CH          = 4,
   parameter int TIMEOUT_SAMPLES = 40000
) (
   input  logic                 audio_clk,
   input  logic                 rst_n_in,
   input  logic                 audio_trigger,
   input  logic [16*NUM_CH-1:0] audio_in,
   input  logic                 cal_start,
   input  logic                 cal_abort,
   input  logic [NUM_CH-1:0]    ch_mask,
   output logic                 calc_trigger,
   output logic                 calc_rst,
   output logic [15:0]          calc_audio,
   input  logic [15:0]          calc_offset,
   input  logic                 calc_produced,
   output logic [16*NUM_CH-1:0] audio_out,
   output logic                 audio_out_valid,
   output logic [NUM_CH-1:0]    offset_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);
   localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, FLUSH, DONE} state_t;
   state_t state_q, state_d;
   logic [NUM_CH-1:0] pending_q, pending_d, offset_valid_q, offset_valid_d;
   logic [SW-1:0] sel_q, sel_d, low;
   logic [15:0] offset_q [NUM_CH];
   logic [15:0] offset_d [NUM_CH];
   logic [16*NUM_CH-1:0] audio_out_q, audio_out_d;
   logic [16:0] diff;
   logic error_q, error_d, timed_out_q, timed_out_d, timeout;
   logic calc_trigger_q, calc_trigger_d, calc_rst_q, calc_rst_d;
   logic busy_q, busy_d, done_q, done_d, audio_out_valid_q, audio_out_valid_d;

`ifdef CAL_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_SAMPLES + 1);
   logic [WW-1:0] wd_q, wd_d;
   assign timeout = state_q == WAIT && audio_trigger && wd_q == WW'(TIMEOUT_SAMPLES - 1);
   assign wd_d = state_q == LAUNCH ? '0 : (state_q == WAIT && audio_trigger) ? wd_q + WW'(1) : wd_q;
   always_ff @(posedge audio_clk or negedge rst_n_in) begin
      if (!rst_n_in) wd_q <= '0;
      else wd_q <= wd_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      low = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (pending_q[i]) low = SW'(i);
   end

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      sel_d          = sel_q;
      offset_d       = offset_q;
      offset_valid_d = offset_valid_q;
      error_d        = error_q;
      timed_out_d    = timed_out_q;
      case (state_q)
         IDLE: if (cal_start) begin
            pending_d   = ch_mask;
            error_d     = 1'b0;
            timed_out_d = 1'b0;
            state_d     = SELECT;
         end
         SELECT: if (cal_abort) state_d = FLUSH;
            else if (pending_q == '0) state_d = DONE;
            else begin
               sel_d   = low;
               state_d = LAUNCH;
            end
         LAUNCH: state_d = cal_abort ? FLUSH : WAIT;
         WAIT: if (cal_abort) state_d = FLUSH;
            else if (calc_produced) begin
               offset_d[sel_q]       = calc_offset;
               offset_valid_d[sel_q] = 1'b1;
               pending_d[sel_q]      = 1'b0;
               state_d               = SELECT;
            end else if (timeout) begin
               error_d               = 1'b1;
               timed_out_d           = 1'b1;
               offset_valid_d[sel_q] = 1'b0;
               state_d               = FLUSH;
            end
         FLUSH:   state_d = timed_out_q ? DONE : IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign calc_trigger_d    = state_d == LAUNCH;
   assign calc_rst_d        = state_d == FLUSH;
   assign busy_d            = state_d != IDLE;
   assign done_d            = state_d == DONE;
   assign audio_out_valid_d = audio_trigger;

   // 17-bit difference; a sign/carry disagreement in the top two bits means overflow
   always_comb begin
      audio_out_d = audio_out_q;
      diff        = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         diff = {audio_in[16*k+15], audio_in[16*k +: 16]} -
                (offset_valid_q[k] ? {offset_q[k][15], offset_q[k]} : 17'd0);
         if (audio_trigger)
            audio_out_d[16*k +: 16] = diff[16] != diff[15] ? (diff[16] ? 16'h8000 : 16'h7fff) : diff[15:0];
      end
   end

   always_ff @(posedge audio_clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q           <= IDLE;
         pending_q         <= '0;
         sel_q             <= '0;
         offset_valid_q    <= '0;
         error_q           <= 1'b0;
         timed_out_q       <= 1'b0;
         calc_trigger_q    <= 1'b0;
         calc_rst_q        <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         audio_out_q       <= '0;
         audio_out_valid_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) offset_q[k] <= '0;
      end else begin
         state_q           <= state_d;
         pending_q         <= pending_d;
         sel_q             <= sel_d;
         offset_valid_q    <= offset_valid_d;
         error_q           <= error_d;
         timed_out_q       <= timed_out_d;
         calc_trigger_q    <= calc_trigger_d;
         calc_rst_q        <= calc_rst_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         audio_out_q       <= audio_out_d;
         audio_out_valid_q <= audio_out_valid_d;
         offset_q          <= offset_d;
      end
   end

   assign calc_audio      = audio_in[16*sel_q +: 16];
   assign calc_trigger    = calc_trigger_q;
   assign calc_rst        = calc_rst_q;
   assign audio_out       = audio_out_q;
   assign audio_out_valid = audio_out_valid_q;
   assign offset_valid    = offset_valid_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
endmodule

// File: tb/tb_offset_cal_scheduler.sv
// tb_offset_cal_scheduler: scoreboard bench with a timestamped event model of the calibration scheduler
module tb_offset_cal_scheduler;
   localparam int N = 4, T = 8, W = 16 * N;
   logic audio_clk = 0, rst_n_in = 1, audio_trigger = 0, cal_start = 0, cal_abort = 0, calc_produced = 0;
   logic [W-1:0] audio_in = '0;
   logic [N-1:0] ch_mask = '0;
   logic [15:0] calc_offset = '0;
   logic calc_trigger, calc_rst, audio_out_valid, busy, done, error;
   logic [15:0] calc_audio;
   logic [W-1:0] audio_out;
   logic [N-1:0] offset_valid;
   int passed = 0, total = 0, e = 0;

   typedef struct { int t; logic [W-1:0] v; } ev_t;
   ev_t exp_q [8][$];
   string nm [8] = '{"audio_out", "calc_trigger", "calc_rst", "done", "offset_valid", "error", "busy_fall", "busy_rise"};

   int ready_at = 0, wait_from = -1, cur = 0, wd = 0, m_off [N];
   bit m_busy = 0, m_err = 0;
   logic [N-1:0] pend = '0, m_valid = '0;

   always #5 audio_clk = ~audio_clk;

   offset_cal_scheduler #(.NUM_CH(N), .TIMEOUT_SAMPLES(T)) dut (
      .audio_clk(audio_clk), .rst_n_in(rst_n_in), .audio_trigger(audio_trigger), .audio_in(audio_in),
      .cal_start(cal_start), .cal_abort(cal_abort), .ch_mask(ch_mask), .calc_trigger(calc_trigger),
      .calc_rst(calc_rst), .calc_audio(calc_audio), .calc_offset(calc_offset), .calc_produced(calc_produced),
      .audio_out(audio_out), .audio_out_valid(audio_out_valid), .offset_valid(offset_valid),
      .busy(busy), .done(done), .error(error));

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, e + 1);
   endtask

   task automatic push(input int k, input int t, input logic [W-1:0] v);
      exp_q[k].push_back('{t: t, v: v});
   endtask

   function automatic int lowest(input logic [N-1:0] m);
      for (int k = 0; k < N; k++) if (m[k]) return k;
      return 0;
   endfunction

   function automatic logic [W-1:0] corrected();
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         int d;
         d = int'($signed(audio_in[16*k +: 16])) - (m_valid[k] ? m_off[k] : 0);
         d = d > 32767 ? 32767 : d < -32768 ? -32768 : d;
         r[16*k +: 16] = 16'(d);
      end
      return r;
   endfunction

   // s is the edge at which the scheduler looks at the remaining channels
   task automatic next_sel(input int s);
      if (pend == '0) begin
         push(3, s + 1, '0);
         push(6, s + 2, '0);
         ready_at = s + 2; m_busy = 0; wait_from = -1;
      end else begin
         cur = lowest(pend);
         push(1, s + 1, W'(cur));
         wait_from = s + 2; wd = 0;
      end
   endtask

   task automatic model_edge(input int n);
      logic [N-1:0] old;
      if (audio_trigger) push(0, n + 1, corrected());
      if (!m_busy && n >= ready_at && cal_start) begin
         pend = ch_mask;
         if (m_err) push(5, n + 1, '0);
         m_err = 0; m_busy = 1;
         push(7, n + 1, '0);
         next_sel(n + 1);
      end else if (m_busy && wait_from >= 0 && n >= wait_from) begin
         if (cal_abort) begin
            push(2, n + 1, '0);
            push(6, n + 2, '0);
            ready_at = n + 2; m_busy = 0; wait_from = -1;
         end else if (calc_produced) begin
            old = m_valid;
            m_off[cur] = int'($signed(calc_offset));
            m_valid[cur] = 1'b1;
            pend[cur] = 1'b0;
            if (old != m_valid) push(4, n + 1, W'(m_valid));
            next_sel(n + 1);
         end
`ifdef CAL_TIMEOUT_EN
         else if (audio_trigger) begin
            wd++;
            if (wd == T) begin
               m_err = 1;
               push(5, n + 1, W'(1));
               if (m_valid[cur]) begin
                  m_valid[cur] = 1'b0;
                  push(4, n + 1, W'(m_valid));
               end
               push(2, n + 1, '0);
               push(3, n + 2, '0);
               push(6, n + 3, '0);
               ready_at = n + 3; m_busy = 0; wait_from = -1;
            end
         end
`endif
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_err = 0; wait_from = -1; cur = 0; pend = '0; m_valid = '0;
      for (int k = 0; k < N; k++) m_off[k] = 0;
      for (int k = 0; k < 8; k++) exp_q[k].delete();
   endtask

   task automatic tick();
      @(posedge audio_clk);
      e++;
      if (rst_n_in) model_edge(e);
      #1;
      audio_trigger = 0; cal_start = 0; cal_abort = 0; calc_produced = 0;
   endtask

   task automatic cycles(input int n, input int pt, input int pp, input int pa, input int ps, input bit rnd);
      repeat (n) begin
         if (rnd) begin
            audio_in = W'({$urandom, $urandom});
            if ($urandom_range(7) == 0) audio_in[16*$urandom_range(N-1) +: 16] = $urandom_range(1) ? 16'h7fff : 16'h8000;
         end
         audio_trigger = $urandom_range(99) < pt;
         calc_produced = $urandom_range(99) < pp;
         calc_offset   = rnd ? 16'($urandom) : audio_in[16*cur +: 16];
         cal_abort     = $urandom_range(99) < pa &&
                         ((m_busy && wait_from >= 0 && e + 1 >= wait_from) || (!m_busy && e + 1 >= ready_at));
         cal_start     = $urandom_range(99) < ps;
         ch_mask       = N'($urandom);
         tick();
      end
   endtask

   task automatic start(input logic [N-1:0] m);
      ch_mask = m; cal_start = 1;
      tick();
   endtask

   task automatic calibrate(input logic [N-1:0] m, input int pp);
      start(m);
      for (int i = 0; i < 400 && (m_busy || e + 1 < ready_at); i++) cycles(1, 30, pp, 0, 0, 0);
      cycles(1, 0, 0, 0, 0, 0);
      chk("sequence ends idle", W'(busy), '0);
   endtask

   task automatic wait_for_ch(input int ch);
      for (int i = 0; i < 400 && !(m_busy && cur == ch && wait_from >= 0 && e + 1 >= wait_from); i++)
         cycles(1, 30, cur == ch ? 0 : 40, 0, 0, 0);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, " audio_out"}, audio_out, '0);
      chk({tag, " audio_out_valid"}, W'(audio_out_valid), '0);
      chk({tag, " offset_valid"}, W'(offset_valid), '0);
      chk({tag, " busy"}, W'(busy), '0);
      chk({tag, " done"}, W'(done), '0);
      chk({tag, " error"}, W'(error), '0);
      chk({tag, " calc_trigger"}, W'(calc_trigger), '0);
      chk({tag, " calc_rst"}, W'(calc_rst), '0);
   endtask

   // monitor: every observable event must match the head of its expected queue, stamped with the edge that samples it
   initial begin
      logic [N-1:0] pv_valid;
      logic pv_err, pv_busy;
      logic [7:0] fire;
      logic [W-1:0] act [8];
      ev_t x;
      pv_valid = '0; pv_err = 0; pv_busy = 0;
      forever begin
         @(negedge audio_clk);
         if (rst_n_in) begin
            fire = {busy && !pv_busy, pv_busy && !busy, error != pv_err, offset_valid != pv_valid,
                    done, calc_rst, calc_trigger, audio_out_valid};
            act[0] = audio_out; act[1] = W'(calc_audio); act[2] = '0; act[3] = '0;
            act[4] = W'(offset_valid); act[5] = W'(error); act[6] = '0; act[7] = '0;
            for (int k = 0; k < 8; k++) begin
               if (fire[k]) begin
                  if (exp_q[k].size() == 0) begin
                     total++;
                     $display("FAIL %s: unexpected event at edge %0d, expected none", nm[k], e + 1);
                  end else begin
                     x = exp_q[k].pop_front();
                     chk({nm[k], " edge"}, W'(e + 1), W'(x.t));
                     chk(nm[k], act[k], k == 1 ? W'(audio_in[16*int'(x.v) +: 16]) : x.v);
                  end
               end
               while (exp_q[k].size() > 0 && exp_q[k][0].t <= e + 1) begin
                  total++;
                  $display("FAIL %s: missing event, got none, expected at edge %0d", nm[k], exp_q[k][0].t);
                  void'(exp_q[k].pop_front());
               end
            end
         end
         pv_valid = offset_valid; pv_err = error; pv_busy = busy;
      end
   end

   initial begin
      model_reset();
      #1 rst_n_in = 0;
      #1 reset_check("reset");
      repeat (3) tick();
      rst_n_in = 1; ready_at = e + 1;
      // two channels with constant DC: offsets equal the DC, so corrected output is 0
      audio_in = {16'd7, 16'hFED4, 16'd55, 16'd100};
      calibrate(4'b0101, 30);
      audio_trigger = 1;
      tick();
      chk("two-ch valid", W'(offset_valid), W'(4'b0101));
      chk("two-ch ch0 out", W'(audio_out[15:0]), '0);
      chk("two-ch ch2 out", W'(audio_out[47:32]), '0);
      // saturation in both directions, ch3 never calibrated
      audio_in[31:16] = 16'd1000;
      calibrate(4'b0010, 30);
      audio_in[31:16] = 16'h8300;
      audio_in[63:48] = 16'd1234;
      audio_trigger = 1;
      tick();
      chk("sat low", W'(audio_out[31:16]), W'(16'h8000));
      chk("ch3 passthrough", W'(audio_out[63:48]), W'(16'd1234));
      audio_in[31:16] = 16'hFC18;
      calibrate(4'b0010, 30);
      audio_in[31:16] = 16'h7D00;
      audio_trigger = 1;
      tick();
      chk("sat high", W'(audio_out[31:16]), W'(16'h7fff));
      // empty mask
      start('0);
      cycles(4, 0, 0, 0, 0, 0);
      // asynchronous reset while waiting on the calculator
      start(4'b0011);
      wait_for_ch(0);
      #1 rst_n_in = 0;
      #1 reset_check("mid-wait reset");
      model_reset();
      repeat (2) tick();
      rst_n_in = 1; ready_at = e + 1;
      // abort during the second channel, with a coincident result that must be discarded
      audio_in = {16'd3, 16'd4, 16'd22, 16'd11};
      start(4'b0011);
      wait_for_ch(1);
      cal_abort = 1; calc_produced = 1; calc_offset = 16'd99;
      tick();
      cycles(4, 20, 0, 0, 0, 0);
      chk("abort valid", W'(offset_valid), W'(4'b0001));
      calibrate(4'b1000, 30);
      chk("restart valid", W'(offset_valid), W'(4'b1001));
`ifdef CAL_TIMEOUT_EN
      calibrate(4'b0001, 0);
      chk("timeout error", W'(error), W'(1));
      chk("timeout valid", W'(offset_valid), W'(4'b1000));
      start(4'b0001);
      chk("error cleared", W'(error), '0);
      for (int i = 0; i < 400 && (m_busy || e + 1 < ready_at); i++) cycles(1, 30, 40, 0, 0, 0);
`endif
      cycles(3000, 30, 15, 3, 10, 1);
      for (int i = 0; i < 400 && (m_busy || e + 1 < ready_at); i++) cycles(1, 30, 50, 0, 0, 1);
      cycles(3, 0, 0, 0, 0, 0);
      @(negedge audio_clk);
      #1;
      for (int k = 0; k < 8; k++) chk({nm[k], " leftover"}, W'(exp_q[k].size()), '0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/offset_cal_scheduler.md
# offset_cal_scheduler

Sequences DC-offset calibration of `NUM_CH` microphone channels through one shared `calculate_offset` instance. It muxes each selected channel into the calculator in turn, triggers it, and captures the result into a per-channel offset register. It then applies saturating offset correction to the live sample stream. It sits between the I2S/ADC front end and the downstream DSP chain.

## Interface
- `NUM_CH`, default 4: number of audio channels (1–8).
- `TIMEOUT_SAMPLES`, default 40000: watchdog limit in `audio_trigger` strobes per channel.

- `audio_clk`  in  1  system audio clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `audio_trigger`  in  1  one-cycle sample strobe.
- `audio_in`  in  16·NUM_CH  signed samples; channel k at [16k+15:16k].
- `cal_start`  in  1  pulse; starts a calibration sequence.
- `cal_abort`  in  1  pulse; abandons the sequence.
- `ch_mask`  in  NUM_CH  channels to calibrate; sampled with `cal_start`.
- `calc_trigger`  out  1  to calculator `offset_trigger`.
- `calc_rst`  out  1  active-high synchronous reset to the calculator.
- `calc_audio`  out  16  selected channel sample to the calculator.
- `calc_offset`  in  16  signed calculator result.
- `calc_produced`  in  1  calculator result strobe.
- `audio_out`  out  16·NUM_CH  corrected samples.
- `audio_out_valid`  out  1  pulse when `audio_out` updates.
- `offset_valid`  out  NUM_CH  channel has a stored offset.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky timeout flag; cleared by the next accepted `cal_start`.

## Operation
- **States:** IDLE, SELECT, LAUNCH, WAIT, FLUSH, DONE. `busy` is high in every state except IDLE.
- **IDLE:** on `cal_start`, latch `pending = ch_mask` and clear `error`, then go to SELECT. `cal_start` is ignored in all other states.
- **SELECT:** if `pending == 0`, go to DONE. Otherwise set `sel` to the lowest set bit of `pending` and go to LAUNCH.
- **LAUNCH:** `calc_trigger` = 1 for this cycle only; clear the watchdog; go to WAIT.
- **WAIT:** on `calc_produced`:
  - `offset[sel] <= calc_offset` and set `offset_valid[sel]`;
  - clear `pending[sel]`;
  - go to SELECT.
- **Timeout (with macro):** each `audio_trigger` increments the watchdog. When it reaches `TIMEOUT_SAMPLES`, set `error`, clear `offset_valid[sel]`, and go to FLUSH.
- **FLUSH:** `calc_rst` = 1 for one cycle. Go to DONE after a timeout, or to IDLE after an abort.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **`cal_abort`** in SELECT, LAUNCH or WAIT goes to FLUSH. No `done` pulse; already-stored offsets are kept. `cal_abort` is ignored in IDLE, FLUSH and DONE.
- **Simultaneous events:**
  - abort and `calc_produced`: abort wins and the result is discarded;
  - `calc_produced` and timeout: `calc_produced` wins.
- **Mux:** `calc_audio = audio_in[sel]`, combinational from registered `sel`, so it is aligned with `audio_trigger`.
- **Correction:** on `audio_trigger`, `audio_out[k] <= sat16(audio_in[k] − (offset_valid[k] ? offset[k] : 0))`.
  - The subtraction is 17-bit signed, clamped to [−32768, 32767].
  - A channel under recalibration keeps using its old offset until the new one is stored.

## Timing
- **Reset:** all outputs 0, all `offset[k]` 0, `sel` 0, `pending` 0, state IDLE. Reset is asynchronous and may occur mid-sequence.
- **Start to trigger:** `cal_start` high at edge t puts SELECT at t+1 and LAUNCH (`calc_trigger` high) at t+2.
- **Result to next trigger:** `calc_produced` high at edge p makes `offset`/`offset_valid` visible at p+1; the next channel's `calc_trigger` is high at p+2.
- **Empty mask:** `cal_start` at t with `ch_mask = 0` gives `done` at t+2.
- **Correction latency:** `audio_out` and the `audio_out_valid` pulse appear one cycle after `audio_trigger`.
- **Abort:** `calc_rst` is high the cycle after `cal_abort` is sampled; `busy` is low one cycle later.

## Configuration
- **`CAL_TIMEOUT_EN` defined:** the watchdog counter (⌈log2(TIMEOUT_SAMPLES+1)⌉ bits) and the timeout path are present.
- **`CAL_TIMEOUT_EN` undefined:**
  - no counter; `error` is tied to 0;
  - WAIT exits only on `calc_produced` or `cal_abort`;
  - FLUSH is reached only by abort.

## Test plan
- **Two-channel sequence:** `ch_mask` = 4'b0101, ch0 = const 100, ch2 = const −300, real calculator. Expect two `calc_trigger` pulses (ch0 then ch2), `offset_valid` = 0101, a single `done` pulse, and `audio_out` ch0 = 0, ch2 = 0 afterwards.
- **Saturation:** `offset[1]` = 1000 with input −32000 gives −32768; `offset[1]` = −1000 with input 32000 gives 32767. Unvalidated ch3 passes through unchanged.
- **Empty mask:** `ch_mask` = 0 gives `done` 2 cycles after `cal_start`, no `calc_trigger`, and `busy` high for 2 cycles.
- **Abort:** `ch_mask` = 0011 with `cal_abort` during ch1 WAIT gives a one-cycle `calc_rst` pulse, `offset_valid` = 0001, no `done`, and `cal_start` accepted again in IDLE.
- **Timeout (macro defined):** `TIMEOUT_SAMPLES` = 8 with a stub calculator that never produces. After 8 `audio_trigger` strobes expect `calc_rst`, `error` = 1, then a `done` pulse; the next `cal_start` clears `error`.
- **Reset mid-WAIT:** assert `rst_n_in` low in WAIT. All outputs go to 0 without a clock edge, and the sequence re-runs correctly after release.
